puf_soc_race_counter: RTL and testbench

- Upstream stage of the PUF comparator; runs one ring-oscillator race per challenge.
- Synchronises two free-running RO outputs and counts their rising edges from a common start.
- Freezes both counts when either counter saturates, or when a timeout expires.
- Presents full flags and counts, held stable, for the comparator to pick the loser.

---
 rtl/puf_soc_race_counter.sv | 156 +++++++++++++++
 tb/tb_puf_soc_race_counter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_soc_race_counter.sv
// Ring-oscillator race counter: upstream stage of the PUF comparator.
// Both RO outputs are synchronised and their rising edges counted from a
// common start. The race ends when either counter saturates (full) or when
// the timeout expires. Counts and flags are then held for the comparator.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for i_start; results of the last race held
// RACE    | counting RO edges and timeout cycles; o_busy high
// DONE    | one-cycle o_done pulse; i_start accepted as in IDLE
module puf_soc_race_counter #(
    parameter int CNT_BIT_SIZE   = 32,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int TMO_BIT_SIZE   = 17
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_ro_0,
    input  logic                    i_ro_1,
    output logic [CNT_BIT_SIZE-1:0] o_cnt_0,
    output logic [CNT_BIT_SIZE-1:0] o_cnt_1,
    output logic                    o_full_0,
    output logic                    o_full_1,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RACE = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A counter one rise away from all ones; reaching all ones ends the race.
    localparam logic [CNT_BIT_SIZE-1:0] CNT_ALMOST = {{(CNT_BIT_SIZE-1){1'b1}}, 1'b0};
    localparam logic [TMO_BIT_SIZE-1:0] TMO_LAST   = TMO_BIT_SIZE'(TIMEOUT_CYCLES - 1);

    state_t state_q, state_d;

    // bit 0/1: two-flop synchroniser, bit 2: edge history
    logic [2:0] ro0_sync_q;
    logic [2:0] ro1_sync_q;
    logic       rise_0;
    logic       rise_1;

    logic [CNT_BIT_SIZE-1:0] cnt0_q, cnt0_d;
    logic [CNT_BIT_SIZE-1:0] cnt1_q, cnt1_d;
    logic                    full0_q, full0_d;
    logic                    full1_q, full1_d;
    logic                    tmo_flag_q, tmo_flag_d;
    logic [TMO_BIT_SIZE-1:0] tmo_cnt_q, tmo_cnt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    hit0;
    logic                    hit1;

    // Synchroniser chains run in every state so edge history is always valid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ro0_sync_q <= 3'b000;
            ro1_sync_q <= 3'b000;
        end else begin
            ro0_sync_q <= {ro0_sync_q[1:0], i_ro_0};
            ro1_sync_q <= {ro1_sync_q[1:0], i_ro_1};
        end
    end

    assign rise_0 = ro0_sync_q[1] & ~ro0_sync_q[2];
    assign rise_1 = ro1_sync_q[1] & ~ro1_sync_q[2];

    // Next-state, counter and flag logic for the race FSM.
    always_comb begin
        state_d    = state_q;
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;
        full0_d    = full0_q;
        full1_d    = full1_q;
        tmo_flag_d = tmo_flag_q;
        tmo_cnt_d  = tmo_cnt_q;
        hit0       = 1'b0;
        hit1       = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (i_start) begin
                    state_d    = ST_RACE;
                    cnt0_d     = '0;
                    cnt1_d     = '0;
                    full0_d    = 1'b0;
                    full1_d    = 1'b0;
                    tmo_flag_d = 1'b0;
                    tmo_cnt_d  = '0;
                end
            end
            ST_RACE: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (rise_0) cnt0_d = cnt0_q + 1'b1;
                if (rise_1) cnt1_d = cnt1_q + 1'b1;
                hit0 = rise_0 && (cnt0_q == CNT_ALMOST);
                hit1 = rise_1 && (cnt1_q == CNT_ALMOST);
                // A full event takes priority over a timeout on the same edge.
                if (hit0 || hit1) begin
                    full0_d = hit0;
                    full1_d = hit1;
                    state_d = ST_DONE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_flag_d = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RACE);
        done_d = (state_d == ST_DONE);
    end

    // State, counters, flags and registered status outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
            full0_q    <= 1'b0;
            full1_q    <= 1'b0;
            tmo_flag_q <= 1'b0;
            tmo_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
            full0_q    <= full0_d;
            full1_q    <= full1_d;
            tmo_flag_q <= tmo_flag_d;
            tmo_cnt_q  <= tmo_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_cnt_0   = cnt0_q;
    assign o_cnt_1   = cnt1_q;
    assign o_full_0  = full0_q;
    assign o_full_1  = full1_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_timeout = tmo_flag_q;

endmodule

// File: tb/tb_puf_soc_race_counter.sv
// Scoreboard bench for puf_soc_race_counter with CNT_BIT_SIZE=4, TIMEOUT_CYCLES=64.
module tb_puf_soc_race_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       ro0;
    logic       ro1;
    logic [3:0] o_cnt_0;
    logic [3:0] o_cnt_1;
    logic       o_full_0;
    logic       o_full_1;
    logic       o_busy;
    logic       o_done;
    logic       o_timeout;

    puf_soc_race_counter #(
        .CNT_BIT_SIZE  (4),
        .TIMEOUT_CYCLES(64),
        .TMO_BIT_SIZE  (7)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_ro_0   (ro0),
        .i_ro_1   (ro1),
        .o_cnt_0  (o_cnt_0),
        .o_cnt_1  (o_cnt_1),
        .o_full_0 (o_full_0),
        .o_full_1 (o_full_1),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt0;
        int c1lo;
        int c1hi;
        int f0;
        int f1;
        int tmo;
        int busy;
    } exp_t;

    localparam int M_OFF    = 0;
    localparam int M_RO0WIN = 1;
    localparam int M_TIE    = 2;
    localparam int M_TMO    = 3;
    localparam int M_TOGGLE = 4;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // RO waveforms as a function of cycles since the reference point.
    function automatic logic [1:0] ro_wave(input int mode, input int c);
        logic a;
        logic b;
        a = 1'b0;
        b = 1'b0;
        case (mode)
            M_RO0WIN: begin a = (c % 4) >= 2; b = (c % 8) >= 4; end
            M_TIE:    begin a = (c % 4) >= 2; b = a; end
            M_TMO:    begin a = (c < 20) && ((c % 4) >= 2); b = 1'b0; end
            M_TOGGLE: begin a = c[0]; b = ~c[0]; end
            default:  begin a = 1'b0; b = 1'b0; end
        endcase
        return {b, a};
    endfunction

    task automatic drive_ro(input int mode, input int c);
        logic [1:0] w;
        w   = ro_wave(mode, c);
        ro0 = w[0];
        ro1 = w[1];
    endtask

    task automatic cmp_results(input string pfx, input exp_t e);
        check({pfx, "_cnt0"}, o_cnt_0, e.cnt0);
        check({pfx, "_cnt1_in_range"}, (o_cnt_1 >= e.c1lo) && (o_cnt_1 <= e.c1hi), 1);
        check({pfx, "_full0"}, o_full_0, e.f0);
        check({pfx, "_full1"}, o_full_1, e.f1);
        check({pfx, "_timeout"}, o_timeout, e.tmo);
    endtask

    // Start a race at the current negedge and run it until o_done.
    task automatic run_race(input string name, input int mode, input int poke_at, input exp_t e);
        int   c;
        int   busy_n;
        logic prev_busy;
        bit   done_seen;
        exp_t got;
        sb_q.push_back(e);
        start = 1'b1;
        drive_ro(mode, 0);
        c         = 0;
        busy_n    = 0;
        prev_busy = 1'b0;
        done_seen = 1'b0;
        while (!done_seen && c < 200) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                check({name, "_start_busy"}, o_busy, 1);
                check({name, "_start_cnt0"}, o_cnt_0, 0);
                check({name, "_start_cnt1"}, o_cnt_1, 0);
                check({name, "_start_flags"}, {o_full_1, o_full_0, o_timeout, o_done}, 0);
            end
            if (o_busy) busy_n++;
            if (o_done) begin
                done_seen = 1'b1;
                start     = 1'b0;
                check({name, "_sb_nonempty"}, sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    got = sb_q.pop_front();
                    cmp_results(name, got);
                    check({name, "_busy_cycles"}, busy_n, got.busy);
                end
                check({name, "_busy_at_done"}, o_busy, 0);
                check({name, "_busy_before_done"}, prev_busy, 1);
            end else begin
                start = (c == poke_at);
                drive_ro(mode, c);
            end
            prev_busy = o_busy;
        end
        check({name, "_done_seen"}, done_seen, 1);
        start = 1'b0;
    endtask

    // Idle for n cycles with RO activity; results must hold and no o_done.
    task automatic idle_hold(input string name, input int n, input int mode, input exp_t e);
        int done_n;
        int busy_n;
        done_n = 0;
        busy_n = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (o_done) done_n++;
            if (o_busy) busy_n++;
            drive_ro(mode, i);
        end
        check({name, "_no_done"}, done_n, 0);
        check({name, "_no_busy"}, busy_n, 0);
        cmp_results(name, e);
    endtask

    initial begin
        exp_t e_zero;
        exp_t e_win;
        exp_t e_tie;
        exp_t e_tmo;
        int   c;
        int   done_n;
        int   busy_n;

        e_zero = '{0, 0, 0, 0, 0, 0, 0};
        e_win  = '{15, 7, 8, 1, 0, 0, 60};
        e_tie  = '{15, 15, 15, 1, 1, 0, 60};
        e_tmo  = '{5, 0, 0, 0, 0, 1, 64};

        // Reset with RO activity.
        rst   = 1'b1;
        start = 1'b0;
        ro0   = 1'b0;
        ro1   = 1'b0;
        done_n = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (o_done) done_n++;
            drive_ro(M_TOGGLE, i);
        end
        @(negedge clk);
        check("reset_no_done", done_n + int'(o_done), 0);
        check("reset_busy", o_busy, 0);
        cmp_results("reset", e_zero);
        rst = 1'b0;
        idle_hold("idle_after_reset", 6, M_TOGGLE, e_zero);
        drive_ro(M_OFF, 0);
        repeat (3) @(negedge clk);

        // RO0 wins, with an ignored i_start mid-race; results held afterwards.
        run_race("ro0_win", M_RO0WIN, 30, e_win);
        idle_hold("ro0_win_hold", 20, M_RO0WIN, e_win);
        drive_ro(M_OFF, 0);
        repeat (3) @(negedge clk);

        // Tie, then a timeout race started during the DONE cycle.
        run_race("tie", M_TIE, -1, e_tie);
        run_race("timeout", M_TMO, -1, e_tmo);
        idle_hold("timeout_hold", 8, M_TOGGLE, e_tmo);
        drive_ro(M_OFF, 0);
        repeat (3) @(negedge clk);

        // Reset in the middle of a race.
        start = 1'b1;
        drive_ro(M_RO0WIN, 0);
        c = 0;
        while (c < 200 && o_cnt_0 != 4'd9) begin
            @(negedge clk);
            c++;
            start = 1'b0;
            drive_ro(M_RO0WIN, c);
        end
        check("midrst_reached_cnt9", o_cnt_0, 9);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_cnt0", o_cnt_0, 0);
        check("midrst_cnt1", o_cnt_1, 0);
        check("midrst_busy", o_busy, 0);
        check("midrst_done", o_done, 0);
        check("midrst_flags", {o_full_1, o_full_0, o_timeout}, 0);
        done_n = 0;
        busy_n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (o_done) done_n++;
            if (o_busy) busy_n++;
            drive_ro(M_RO0WIN, c + i);
        end
        check("midrst_no_done_after", done_n, 0);
        check("midrst_no_busy_after", busy_n, 0);
        drive_ro(M_OFF, 0);
        repeat (3) @(negedge clk);

        // Normal race after the aborted one.
        run_race("after_rst", M_RO0WIN, -1, e_win);
        @(negedge clk);
        check("after_rst_done_one_cycle", o_done, 0);
        check("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
